// File: rtl/dvi_timing_gen_if.sv
// Pixel-side bundle of the DVI raster timing generator.
// The generator takes the master modport; the pixel source and sink take slave.
interface dvi_timing_gen_if #(
  parameter int DATA_W = 24
);
  logic              en;
  logic [DATA_W-1:0] pix;
  logic              req;
  logic [10:0]       xpos;
  logic [10:0]       ypos;
  logic              hs;
  logic              vs;
  logic              de;
  logic [DATA_W-1:0] data;
  logic              frame_start;
  logic              busy;

  modport master (
    input  en, pix,
    output req, xpos, ypos, hs, vs, de, data, frame_start, busy
  );

  modport slave (
    output en, pix,
    input  req, xpos, ypos, hs, vs, de, data, frame_start, busy
  );
endinterface

// File: rtl/dvi_timing_gen.sv
// DVI/VGA raster timing generator with look-ahead pixel requests.
// Define DVI_TEST_PATTERN_EN to replace the pixel input with 8 colour bars.
module dvi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int DATA_W   = 24,
  parameter int REQ_LEAD = 2
) (
  input  logic clk,
  input  logic rst,
  dvi_timing_gen_if.master bus
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] LEAD   = 12'(REQ_LEAD);
  localparam logic [11:0] H_TOTW = 12'(H_TOT);
  localparam logic        HS_ON  = (HS_POL != 0);
  localparam logic        VS_ON  = (VS_POL != 0);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("porch and sync widths must be at least 1");
  end
  if (H_TOT > 2047 || V_TOT > 2047) begin : g_bad_total
    $error("raster totals must not exceed 2047");
  end
  if (REQ_LEAD < 1 || REQ_LEAD > H_BP) begin : g_bad_lead
    $error("REQ_LEAD must lie in 1..H_BP");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  state_t            state_n;
  logic [10:0]       hcnt;
  logic [10:0]       vcnt;
  logic              last;
  logic              act;
  logic              in_hs;
  logic              in_vs;
  logic [11:0]       h_sum;
  logic [10:0]       h_la;
  logic [10:0]       v_la;
  logic              req_n;
  logic [DATA_W-1:0] pixel;

  assign last  = (hcnt == H_LAST) && (vcnt == V_LAST);
  assign act   = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign in_hs = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign in_vs = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign bus.busy = (state == RUN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Start on request; stop only once the last pixel of a frame has gone
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.en) state_n = RUN;
      RUN:  if (last && !bus.en) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Raster counters, parked at the origin whenever not running
  always_ff @(posedge clk or posedge rst) begin
    if (rst || state != RUN) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 11'd1;
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  // Raster position REQ_LEAD clocks ahead; lead <= H_BP keeps the wrap to one line
  always_comb begin
    h_sum = {1'b0, hcnt} + LEAD;
    h_la  = h_sum[10:0];
    v_la  = vcnt;
    if (h_sum >= H_TOTW) begin
      h_la = 11'(h_sum - H_TOTW);
      v_la = (vcnt == V_LAST) ? '0 : vcnt + 11'd1;
    end
    req_n = (h_la < H_ACT) && (v_la < V_ACT);
  end

`ifdef DVI_TEST_PATTERN_EN
  localparam int CW = DATA_W / 3;
  logic [2:0]        bar;
  logic [DATA_W-1:0] color;
  logic              unused_pix;

  assign unused_pix = ^bus.pix;

  // Bar index x*8/H_ACTIVE; RGB bits are the inverted index bits 1, 2, 0
  always_comb begin
    bar   = 3'(({3'b0, hcnt} * 14'd8) / 14'(H_ACTIVE));
    color = '0;
    color[3*CW-1:0] = {{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}};
  end
  assign pixel = color;
`else
  assign pixel = bus.pix;
`endif

  // Registered video outputs, one clock behind the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hs          <= ~HS_ON;
      bus.vs          <= ~VS_ON;
      bus.de          <= 1'b0;
      bus.data        <= '0;
      bus.req         <= 1'b0;
      bus.xpos        <= '0;
      bus.ypos        <= '0;
      bus.frame_start <= 1'b0;
    end else if (state == RUN) begin
      bus.hs          <= in_hs ? HS_ON : ~HS_ON;
      bus.vs          <= in_vs ? VS_ON : ~VS_ON;
      bus.de          <= act;
      bus.data        <= act ? pixel : '0;
      bus.req         <= req_n;
      bus.xpos        <= req_n ? h_la : '0;
      bus.ypos        <= req_n ? v_la : '0;
      bus.frame_start <= (hcnt == '0) && (vcnt == '0);
    end else begin
      bus.hs          <= ~HS_ON;
      bus.vs          <= ~VS_ON;
      bus.de          <= 1'b0;
      bus.data        <= '0;
      bus.req         <= 1'b0;
      bus.xpos        <= '0;
      bus.ypos        <= '0;
      bus.frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen on a 14x7 raster, both sync polarities.
// Reference model works from the linear clock index within a run.
module tb_dvi_timing_gen;
  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FR = HT * VT;
  localparam int L  = 2;
  localparam logic [23:0] FILL = 24'hC0FFEE;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] pix;

  dvi_timing_gen_if #(.DATA_W(24)) b0 ();
  dvi_timing_gen_if #(.DATA_W(24)) b1 ();

  assign b0.en  = en;
  assign b1.en  = en;
  assign b0.pix = pix;
  assign b1.pix = pix;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .DATA_W(24), .REQ_LEAD(L)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .DATA_W(24), .REQ_LEAD(L)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int o;
    bit de, hs, vs, fs, req;
    int x, y;
  } vec_t;

  vec_t        tbl [12];
  logic [23:0] bars [8];
  int          total = 0;
  int          bad = 0;
  bit          m_run = 0;
  int          m_k = 0;
  int          last_pos = -1;
  bit          prev_req = 0;
  logic [10:0] prev_x = '0;
  logic [10:0] prev_y = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input int pos);
    bit a = 0, hs_on = 0, vs_on = 0, fs = 0, rq = 0;
    int h = 0, v = 0, h2 = 0, v2 = 0;
    logic [23:0] d = '0;
    if (pos >= 0) begin
      h     = pos % HT;
      v     = (pos / HT) % VT;
      a     = (h < HA) && (v < VA);
      hs_on = (h >= HA + HF) && (h < HA + HF + HSY);
      vs_on = (v >= VA + VF) && (v < VA + VF + VSY);
      fs    = (pos % FR) == 0;
      h2    = (pos + L) % HT;
      v2    = ((pos + L) / HT) % VT;
      rq    = (h2 < HA) && (v2 < VA);
`ifdef DVI_TEST_PATTERN_EN
      if (a) d = bars[(h * 8) / HA];
`else
      if (a) d = (pos >= L) ? {2'b0, 11'(v), 11'(h)} : pix;
`endif
    end
    chk("de", 32'(b0.de), 32'(a));
    chk("hs0", 32'(b0.hs), 32'(!hs_on));
    chk("vs0", 32'(b0.vs), 32'(!vs_on));
    chk("hs1", 32'(b1.hs), 32'(hs_on));
    chk("vs1", 32'(b1.vs), 32'(vs_on));
    chk("de1", 32'(b1.de), 32'(a));
    chk("frame_start", 32'(b0.frame_start), 32'(fs));
    chk("req", 32'(b0.req), 32'(rq));
    chk("xpos", 32'(b0.xpos), rq ? 32'(h2) : 32'd0);
    chk("ypos", 32'(b0.ypos), rq ? 32'(v2) : 32'd0);
    chk("data", 32'(b0.data), 32'(d));
    chk("busy", 32'(b0.busy), 32'(m_run));
  endtask

  task automatic tick();
    bit en_at, rst_at;
    int pos;
    en_at  = en;
    rst_at = rst;
    @(posedge clk);
    #1;
    pos = -1;
    if (rst_at) begin
      m_run = 0;
    end else if (!m_run) begin
      if (en_at) begin
        m_run = 1;
        m_k   = 0;
      end
    end else begin
      pos = m_k;
      if ((m_k % FR) == FR - 1 && !en_at) m_run = 0;
      else m_k++;
    end
    last_pos = pos;
    check_out(pos);
    pix      = prev_req ? {2'b0, prev_y, prev_x} : FILL;
    prev_req = b0.req;
    prev_x   = b0.xpos;
    prev_y   = b0.ypos;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    m_run = 0;
    check_out(-1);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit hit;
    rst = 1'b1;
    en  = 1'b0;
    pix = FILL;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    tbl[0]  = '{1,  1, 1, 1, 1, 1, 2, 0};
    tbl[1]  = '{7,  1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{8,  1, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{9,  0, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{11, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{12, 0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{13, 0, 1, 1, 0, 1, 0, 1};
    tbl[7]  = '{15, 1, 1, 1, 0, 1, 2, 1};
    tbl[8]  = '{55, 0, 1, 1, 0, 0, 0, 0};
    tbl[9]  = '{71, 0, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{85, 0, 1, 1, 0, 0, 0, 0};
    tbl[11] = '{97, 0, 1, 1, 0, 1, 0, 0};

    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    en = 1'b1;
    tick();
    for (int o = 1; o <= 99; o++) begin
      tick();
      for (int i = 0; i < 12; i++) begin
        if (tbl[i].o == o) begin
          chk($sformatf("tbl%0d_de", o), 32'(b0.de), 32'(tbl[i].de));
          chk($sformatf("tbl%0d_hs", o), 32'(b0.hs), 32'(tbl[i].hs));
          chk($sformatf("tbl%0d_vs", o), 32'(b0.vs), 32'(tbl[i].vs));
          chk($sformatf("tbl%0d_fs", o), 32'(b0.frame_start),
              32'(tbl[i].fs));
          chk($sformatf("tbl%0d_req", o), 32'(b0.req), 32'(tbl[i].req));
          chk($sformatf("tbl%0d_x", o), 32'(b0.xpos), 32'(tbl[i].x));
          chk($sformatf("tbl%0d_y", o), 32'(b0.ypos), 32'(tbl[i].y));
        end
      end
    end

    hit = 0;
    for (int i = 0; i < 3 * FR && !hit; i++) begin
      tick();
      if (last_pos >= 0 && (last_pos % FR) == 2 * HT + 3) hit = 1;
    end
    chk("stop_align_found", 32'(hit), 32'd1);
    en = 1'b0;
    n = 0;
    while (b0.busy && n < 3 * FR) begin
      tick();
      n++;
    end
    chk("stop_cycles", n, 66);
    chk("stop_hs", 32'(b0.hs), 32'd1);
    chk("stop_vs", 32'(b0.vs), 32'd1);
    chk("stop_de", 32'(b0.de), 32'd0);
    repeat (4) tick();
    chk("still_idle", 32'(b0.busy), 32'd0);
    en = 1'b1;
    tick();
    chk("restart_busy", 32'(b0.busy), 32'd1);
    tick();
    chk("restart_fs", 32'(b0.frame_start), 32'd1);
    chk("restart_de", 32'(b0.de), 32'd1);

    hit = 0;
    for (int i = 0; i < 2 * FR && !hit; i++) begin
      tick();
      if (last_pos >= 0 && (last_pos % HT) == 5 &&
          (last_pos % FR) < VA * HT) hit = 1;
    end
    chk("mid_pixel_found", 32'(hit), 32'd1);
    chk("mid_de_before", 32'(b0.de), 32'd1);
    en = 1'b0;
    do_reset();
    chk("rst_busy", 32'(b0.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_de", 32'(b0.de), 32'd0);
    end
    en = 1'b1;
    tick();
    tick();
    chk("rst_restart_fs", 32'(b0.frame_start), 32'd1);

    for (int i = 0; i < 4000; i++) begin
      if (en ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 4) == 0))
        en = ~en;
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
